// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared mode constants, FSM states and sizing for the data-memory path
package dmem_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 512;

  localparam logic [2:0] MODE_BS = 3'b000;
  localparam logic [2:0] MODE_HS = 3'b001;
  localparam logic [2:0] MODE_W  = 3'b010;
  localparam logic [2:0] MODE_BU = 3'b011;
  localparam logic [2:0] MODE_HU = 3'b100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

endpackage

// File: rtl/dmem_access_check.sv
// rtl/dmem_access_check.sv - combinational mode/alignment/range legality check for one access
module dmem_access_check
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic              we,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [2:0]      span_m1;
  logic            misaligned;
  logic            bad_mode;
  logic [ADDR_W:0] last_byte;

  always_comb begin
    span_m1    = 3'd0;
    misaligned = 1'b0;
    bad_mode   = (mode > MODE_HU);
    if (we) begin
      // The memory always writes a full word on a store, whatever the mode.
      span_m1    = 3'd3;
      misaligned = |addr[1:0];
    end else begin
      case (mode)
        MODE_HS, MODE_HU: begin
          span_m1    = 3'd1;
          misaligned = addr[0];
        end
        MODE_W: begin
          span_m1    = 3'd3;
          misaligned = |addr[1:0];
        end
        default: begin
          span_m1    = 3'd0;
          misaligned = 1'b0;
        end
      endcase
    end
    // One extra bit so a high address cannot wrap back into range.
    last_byte = {1'b0, addr} + (ADDR_W+1)'(span_m1);
    err       = bad_mode | misaligned | (last_byte >= LIMIT);
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and one-cycle sequencer for the data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [2:0]        mode0,
  input  logic [2:0]        mode1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [31:0]       wdata0,
  input  logic [31:0]       wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [31:0]       rdata,
  output logic              mem_we,
  output logic [2:0]        mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic              owner_q;
  logic              we_q;
  logic [2:0]        mode_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;

  logic              any_req;
  logic              win;
  logic              sel_we;
  logic [2:0]        sel_mode;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              chk_err;

  assign any_req   = req0 | req1;
  // last_q names the port granted last; on a tie the other port wins.
  assign win       = (req0 & req1) ? ~last_q : req1;
  assign sel_we    = win ? we1    : we0;
  assign sel_mode  = win ? mode1  : mode0;
  assign sel_addr  = win ? addr1  : addr0;
  assign sel_wdata = win ? wdata1 : wdata0;

  dmem_access_check #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(MEM_BYTES)
  ) u_check (
    .we  (sel_we),
    .mode(sel_mode),
    .addr(sel_addr),
    .err (chk_err)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;
    err0      = 1'b0;
    err1      = 1'b0;
    mem_we    = 1'b0;
    mem_mode  = MODE_W;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        if (any_req && rst) begin
          gnt0    = ~win;
          gnt1    = win;
          state_d = chk_err ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_we    = we_q;
        mem_mode  = mode_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = RESP;
      end
      RESP: begin
        done0   = ~owner_q;
        done1   = owner_q;
        err0    = ~owner_q & err_q;
        err1    = owner_q & err_q;
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      mode_q  <= MODE_W;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      if (state_q == IDLE && any_req) begin
        owner_q <= win;
        we_q    <= sel_we;
        mode_q  <= sel_mode;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        err_q   <= chk_err;
        rdata_q <= '0;
      end
      if (state_q == ACCESS) begin
        rdata_q <= we_q ? 32'h0 : mem_rdata;
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a 512-byte big-endian memory model
module tb_dmem_arbiter;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [2:0]  mode0 = MODE_W, mode1 = MODE_W;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata;
  logic        mem_we;
  logic [2:0]  mem_mode;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(512), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .mode0(mode0), .mode1(mode1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_we(mem_we), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int mem_we_cycles = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fill(input logic [2:0] mode, input logic [31:0] w);
    case (mode)
      MODE_BS: return {{24{w[7]}}, w[7:0]};
      MODE_BU: return {24'h0, w[7:0]};
      MODE_HS: return {{16{w[15]}}, w[15:0]};
      MODE_HU: return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // Memory model seen by the DUT.
  logic [7:0]  mem_b [512];
  logic [8:0]  ma;
  logic [31:0] st_word;
  assign ma      = mem_addr[8:0];
  assign st_word = fill(mem_mode, mem_wdata);
  always_comb begin
    case (mem_mode)
      MODE_BS: mem_rdata = {{24{mem_b[ma][7]}}, mem_b[ma]};
      MODE_BU: mem_rdata = {24'h0, mem_b[ma]};
      MODE_HS: mem_rdata = {{16{mem_b[ma][7]}}, mem_b[ma], mem_b[ma+9'd1]};
      MODE_HU: mem_rdata = {16'h0, mem_b[ma], mem_b[ma+9'd1]};
      default: mem_rdata = {mem_b[ma], mem_b[ma+9'd1], mem_b[ma+9'd2], mem_b[ma+9'd3]};
    endcase
  end
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      mem_b[ma]      <= st_word[31:24];
      mem_b[ma+9'd1] <= st_word[23:16];
      mem_b[ma+9'd2] <= st_word[15:8];
      mem_b[ma+9'd3] <= st_word[7:0];
    end
  end

  // Reference model: shadow memory updated when a legal store is granted.
  logic [7:0] ref_mem [512];

  function automatic logic ref_err(input logic we, input logic [2:0] mode, input logic [31:0] addr);
    int unsigned n;
    logic [33:0] hi;
    if (mode > 3'd4) return 1'b1;
    if (we || mode == MODE_W) n = 4;
    else if (mode == MODE_HS || mode == MODE_HU) n = 2;
    else n = 1;
    if ((addr % n) != 0) return 1'b1;
    hi = {2'b00, addr} + 34'(n) - 34'd1;
    return (hi >= 34'd512);
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] mode, input logic [31:0] addr);
    logic [31:0] w;
    int a;
    a = int'(addr[8:0]);
    case (mode)
      MODE_BS, MODE_BU: w = {24'h0, ref_mem[a]};
      MODE_HS, MODE_HU: w = {16'h0, ref_mem[a], ref_mem[a+1]};
      default:          w = {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    endcase
    return fill(mode, w);
  endfunction

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] data;
    int          gcyc;
  } exp_t;

  exp_t sb[$];
  logic gnt_log[$];

  always @(negedge clk) begin
    exp_t        e, o;
    logic        p, w;
    logic [2:0]  m;
    logic [31:0] a, d, sw;
    if (rst) begin
      if (mem_we) mem_we_cycles++;
      if (gnt0 && gnt1) check_eq("gnt_both", 32'd1, 32'd0);
      if (done0 && done1) check_eq("done_both", 32'd1, 32'd0);
      if (gnt0 || gnt1) begin
        p = gnt1;
        w = p ? we1 : we0;
        m = p ? mode1 : mode0;
        a = p ? addr1 : addr0;
        d = p ? wdata1 : wdata0;
        e.port = p;
        e.err  = ref_err(w, m, a);
        e.data = (!e.err && !w) ? ref_load(m, a) : 32'h0;
        e.gcyc = cyc;
        if (!e.err && w) begin
          sw = fill(m, d);
          ref_mem[int'(a[8:0])]     = sw[31:24];
          ref_mem[int'(a[8:0]) + 1] = sw[23:16];
          ref_mem[int'(a[8:0]) + 2] = sw[15:8];
          ref_mem[int'(a[8:0]) + 3] = sw[7:0];
        end
        sb.push_back(e);
        gnt_log.push_back(p);
      end
      if (done0 || done1) begin
        if (sb.size() == 0) begin
          check_eq("done_unexpected", 32'd1, 32'd0);
        end else begin
          o = sb.pop_front();
          check_eq("done_port", {31'h0, done1}, {31'h0, o.port});
          check_eq("err", {31'h0, done1 ? err1 : err0}, {31'h0, o.err});
          check_eq("err_other", {31'h0, done1 ? err0 : err1}, 32'h0);
          check_eq("rdata", rdata, o.data);
          check_eq("latency", 32'(cyc - o.gcyc), o.err ? 32'd1 : 32'd2);
        end
      end
    end
  end

  task automatic access(input logic p, input logic w, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    if (p) begin we1 = w; mode1 = m; addr1 = a; wdata1 = d; req1 = 1'b1; end
    else   begin we0 = w; mode0 = m; addr0 = a; wdata0 = d; req0 = 1'b1; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = p ? gnt1 : gnt0;
    end
    if (!got) check_eq("gnt_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (p) req1 = 1'b0; else req0 = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    if (sb.size() != 0) check_eq("done_timeout", sb.size(), 32'd0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    sb.delete();
    gnt_log.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int we_before;
    for (int i = 0; i < 512; i++) begin
      v = 8'($urandom);
      mem_b[i]   = v;
      ref_mem[i] = v;
    end

    #2;
    check_eq("rst_gnt",      {30'h0, gnt1, gnt0}, 32'h0);
    check_eq("rst_done",     {30'h0, done1, done0}, 32'h0);
    check_eq("rst_err",      {30'h0, err1, err0}, 32'h0);
    check_eq("rst_rdata",    rdata, 32'h0);
    check_eq("rst_mem_we",   {31'h0, mem_we}, 32'h0);
    check_eq("rst_mem_mode", {29'h0, mem_mode}, 32'h2);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdat", mem_wdata, 32'h0);
    apply_reset();

    access(1'b0, 1'b1, MODE_W, 32'h010, 32'hDEADBEEF);
    access(1'b0, 1'b0, MODE_W, 32'h010, 32'h0);
    check_eq("load_word", rdata, 32'hDEADBEEF);
    access(1'b0, 1'b0, MODE_BS, 32'h013, 32'h0);
    check_eq("load_bs", rdata, 32'hFFFFFFEF);
    access(1'b0, 1'b0, MODE_BU, 32'h013, 32'h0);
    check_eq("load_bu", rdata, 32'h000000EF);

    we_before = mem_we_cycles;
    access(1'b1, 1'b1, MODE_W, 32'h012, 32'h12345678);
    check_eq("err_store_no_we", 32'(mem_we_cycles), 32'(we_before));
    access(1'b1, 1'b0, MODE_W, 32'h010, 32'h0);
    check_eq("reload_unchanged", rdata, 32'hDEADBEEF);
    access(1'b0, 1'b0, MODE_W, 32'h1FE, 32'h0);
    access(1'b0, 1'b0, 3'b110, 32'h000, 32'h0);
    access(1'b0, 1'b1, MODE_W, 32'h1FC, 32'h11223344);
    access(1'b0, 1'b0, MODE_HU, 32'h1FE, 32'h0);
    check_eq("half_top", rdata, 32'h00003344);
    access(1'b1, 1'b0, MODE_HS, 32'h1FF, 32'h0);
    access(1'b0, 1'b0, MODE_W, 32'hFFFF_FFFC, 32'h0);

    apply_reset();
    we0 = 1'b0; mode0 = MODE_W;  addr0 = 32'h010;
    we1 = 1'b0; mode1 = MODE_BU; addr1 = 32'h013;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 40 && gnt_log.size() < 4; i++) @(negedge clk);
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check_eq("rr_count", gnt_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check_eq($sformatf("rr_order%0d", i), {31'h0, gnt_log[i]}, 32'(i % 2));

    we0 = 1'b1; mode0 = MODE_W; addr0 = 32'h020; wdata0 = 32'hCAFEF00D; req0 = 1'b1;
    for (int i = 0; i < 20 && !gnt0; i++) @(negedge clk);
    @(posedge clk); #1;
    check_eq("abort_we_in_access", {31'h0, mem_we}, 32'h1);
    rst = 1'b0;
    sb.delete();
    #1;
    check_eq("abort_we_dropped", {31'h0, mem_we}, 32'h0);
    @(negedge clk);
    check_eq("abort_no_done", {30'h0, done1, done0}, 32'h0);
    check_eq("abort_no_gnt", {30'h0, gnt1, gnt0}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("regrant_first_clk", {31'h0, gnt0}, 32'h1);
    @(posedge clk); #1;
    req0 = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    access(1'b0, 1'b0, MODE_W, 32'h020, 32'h0);
    check_eq("retry_value", rdata, 32'hCAFEF00D);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
